// File: rtl/mem_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states, owner tags,
// the latched memory request record and the default starvation bound.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_RSP = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } mem_req_t;

   localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arb_grant.sv
// Priority select between IFU and LSU. LSU normally wins, but IFU is forced
// through once it has watched STARVE_MAX back-to-back LSU grants.
module mem_arb_grant
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic ifu_valid,
   input  logic lsu_valid,
   output logic gnt_ifu,
   output logic gnt_lsu
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0] starve_cnt;
   logic       ifu_turn;

   assign ifu_turn = ifu_valid && (starve_cnt == STARVE_LIM);
   assign gnt_lsu  = en && lsu_valid && !ifu_turn;
   assign gnt_ifu  = en && ifu_valid && !gnt_lsu;

   // Counts only LSU wins that actually made a waiting IFU lose.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         starve_cnt <= '0;
      else if (gnt_ifu)
         starve_cnt <= '0;
      else if (gnt_lsu && ifu_valid && (starve_cnt != STARVE_LIM))
         starve_cnt <= starve_cnt + 4'd1;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (IFU, LSU) arbiter onto a single memory port with exactly one
// transaction in flight; responses are routed back to the granted owner.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ifu_req_valid,
   input  logic [31:0] ifu_req_addr,
   output logic        ifu_req_ready,
   output logic        ifu_rsp_valid,
   output logic [31:0] ifu_rsp_data,
   input  logic        lsu_req_valid,
   input  logic [31:0] lsu_req_addr,
   input  logic [3:0]  lsu_req_wstrb,
   input  logic [31:0] lsu_req_wdata,
   output logic        lsu_req_ready,
   output logic        lsu_rsp_valid,
   output logic [31:0] lsu_rsp_rdata,
   output logic        mem_req_valid,
   output logic [31:0] mem_req_addr,
   output logic [3:0]  mem_req_wstrb,
   output logic [31:0] mem_req_wdata,
   input  logic        mem_req_ready,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_rdata,
   output logic        err_spurious
);

   state_t   state, state_nx;
   owner_t   owner;
   mem_req_t req_q;
   logic     gnt_ifu, gnt_lsu;
   logic     rsp_take;

   mem_arb_grant #(.STARVE_MAX(STARVE_MAX)) u_grant (
      .clk       (clk),
      .rst       (rst),
      .en        (state == IDLE),
      .ifu_valid (ifu_req_valid),
      .lsu_valid (lsu_req_valid),
      .gnt_ifu   (gnt_ifu),
      .gnt_lsu   (gnt_lsu)
   );

   assign ifu_req_ready = gnt_ifu;
   assign lsu_req_ready = gnt_lsu;
   assign mem_req_valid = (state == REQ);
   assign mem_req_addr  = req_q.addr;
   assign mem_req_wstrb = req_q.wstrb;
   assign mem_req_wdata = req_q.wdata;
   assign rsp_take      = (state == WAIT_RSP) && mem_rsp_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (gnt_ifu || gnt_lsu) state_nx = REQ;
         REQ:      if (mem_req_ready)      state_nx = WAIT_RSP;
         WAIT_RSP: if (mem_rsp_valid)      state_nx = IDLE;
         default:                          state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner         <= OWN_IFU;
         req_q         <= '0;
         ifu_rsp_valid <= 1'b0;
         ifu_rsp_data  <= '0;
         lsu_rsp_valid <= 1'b0;
         lsu_rsp_rdata <= '0;
         err_spurious  <= 1'b0;
      end else begin
         ifu_rsp_valid <= 1'b0;
         lsu_rsp_valid <= 1'b0;
         if (gnt_lsu) begin
            owner <= OWN_LSU;
            req_q <= '{addr: lsu_req_addr, wstrb: lsu_req_wstrb, wdata: lsu_req_wdata};
         end else if (gnt_ifu) begin
            owner <= OWN_IFU;
            req_q <= '{addr: ifu_req_addr, wstrb: 4'h0, wdata: 32'h0};
         end
         if (rsp_take) begin
            if (owner == OWN_LSU) begin
               lsu_rsp_valid <= 1'b1;
               lsu_rsp_rdata <= mem_rsp_rdata;
            end else begin
               ifu_rsp_valid <= 1'b1;
               ifu_rsp_data  <= mem_rsp_rdata;
            end
         end
         // A response with nothing outstanding is dropped but remembered.
         if (mem_rsp_valid && (state != WAIT_RSP))
            err_spurious <= 1'b1;
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, max consecutive LSU grants while IFU waits (range 1..15).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 ifu_req_valid  input  1  fetch request.
REQ-005 ifu_req_addr  input  32  fetch address.
REQ-006 ifu_req_ready  output  1  fetch request accepted this cycle.
REQ-007 ifu_rsp_valid  output  1  fetch data valid, one-cycle pulse.
REQ-008 ifu_rsp_data  output  32  fetched instruction.
REQ-009 lsu_req_valid  input  1  load/store request.
REQ-010 lsu_req_addr  input  32  data address.
REQ-011 lsu_req_wstrb  input  4  byte write strobes; 0 = load.
REQ-012 lsu_req_wdata  input  32  store data.
REQ-013 lsu_req_ready  output  1  load/store accepted this cycle.
REQ-014 lsu_rsp_valid  output  1  load data / store ack, one-cycle pulse.
REQ-015 lsu_rsp_rdata  output  32  load data.
REQ-016 mem_req_valid / mem_req_addr / mem_req_wstrb / mem_req_wdata  output  1/32/4/32  shared memory port request.
REQ-017 mem_req_ready  input  1  memory accepts request.
REQ-018 mem_rsp_valid / mem_rsp_rdata  input  1/32  memory response (reads and writes both respond).
REQ-019 err_spurious  output  1  sticky: mem_rsp_valid seen outside WAIT_RSP.

Function
REQ-020 FSM states IDLE, REQ, WAIT_RSP; exactly one transaction outstanding.
REQ-021 IDLE: if any req_valid, grant one; granted *_req_ready high same cycle (combinational from valids), addr/wstrb/wdata and owner latched; next state REQ.
REQ-022 At most one *_req_ready high per cycle; both low outside IDLE.
REQ-023 Priority: LSU over IFU, except when starve_cnt == STARVE_MAX and ifu_req_valid, then IFU wins.
REQ-024 starve_cnt (4 bit): +1 on LSU grant with ifu_req_valid high, cleared on IFU grant, saturates at STARVE_MAX; unchanged otherwise.
REQ-025 IFU grant drives mem_req_wstrb = 0, wdata = 0.
REQ-026 REQ: mem_req_valid high, fields from latched regs, stable until mem_req_ready; on mem_req_valid & mem_req_ready go WAIT_RSP.
REQ-027 WAIT_RSP: on mem_rsp_valid, register mem_rsp_rdata into owner's rsp_data, pulse owner's rsp_valid next cycle, go IDLE.
REQ-028 Minimum latency: grant cycle N, mem_req_valid from N+1, response pulse at M+1 where M = mem_rsp_valid cycle; next grant possible at M+1.
REQ-029 rsp_data registers hold last value until next response to same owner.
REQ-030 mem_rsp_valid in IDLE or REQ: ignored, err_spurious set until reset.
REQ-031 Requesters hold req_valid and fields until ready; arbiter does not check this.

Reset
REQ-032 On rst low, asynchronously: state IDLE, starve_cnt 0, owner IFU, all outputs 0 including rsp_data and err_spurious.
REQ-033 Reset mid-transaction drops it; no rsp pulse issued for it after release.
REQ-034 First grant possible in first clock edge after rst rises.

Structure
REQ-035 Package mem_arb_pkg holds state enum (IDLE/REQ/WAIT_RSP), owner enum (OWN_IFU/OWN_LSU), default STARVE_MAX.
REQ-036 One sub-module mem_arb_grant: priority select + starve_cnt; FSM and data regs stay in mem_arbiter.

Verification
REQ-037 IFU only, addr 0x8000_0000, mem_req_ready=1, rsp 0x0000_0013 two cycles later -> ifu_req_ready at N, mem_req_valid N+1, ifu_rsp_valid with 0x13 at M+1.
REQ-038 Both valid every cycle, STARVE_MAX=4 -> grant order LSU,LSU,LSU,LSU,IFU, repeating; never both ready.
REQ-039 LSU store addr 0x100 wstrb 0xF wdata 0xDEADBEEF, mem_req_ready low 3 cycles -> mem_req fields stable all 3 cycles; lsu_rsp_valid after ack.
REQ-040 mem_rsp_valid pulsed in IDLE -> err_spurious 1 and stays 1; no rsp pulse to either requester.
REQ-041 rst low during WAIT_RSP -> outputs 0 immediately; late mem_rsp_valid after release sets err_spurious, no rsp pulse.
